// File: rtl/axi_remap_pkg.sv
// Types and constants shared by the AXI ID-remapper blocks.
// Burst lengths are carried as raw 8-bit awlen values (beats - 1).
package axi_remap_pkg;

    localparam int AXI_LEN_W = 8;

    typedef logic [AXI_LEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

endpackage

// File: rtl/axi_len_fifo.sv
// Small FIFO of AW burst lengths, one entry per outstanding write burst.
// The head entry describes the burst whose W beats are currently being forwarded.
module axi_len_fifo
    import axi_remap_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = AXI_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign full  = (cnt == (PTR_W+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/axi_w_gate.sv
// Write-channel ordering stage: holds W beats until their AW burst has gone
// downstream, regenerates wlast from awlen and flags upstream wlast mismatches.
module axi_w_gate
    import axi_remap_pkg::*;
#(
    parameter int AXI_ADDRESS_W = 32,
    parameter int AXI_DATA_W    = 64,
    parameter int AXI_NUMBYTES  = AXI_DATA_W/8,
    parameter int AXI_USER_W    = 6,
    parameter int AXI_ID_W      = 4,
    parameter int DEPTH         = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [AXI_ID_W-1:0]       targ_awid_i,
    input  logic [AXI_ADDRESS_W-1:0]  targ_awaddr_i,
    input  logic [7:0]                targ_awlen_i,
    input  logic [2:0]                targ_awsize_i,
    input  logic [1:0]                targ_awburst_i,
    input  logic                      targ_awlock_i,
    input  logic [3:0]                targ_awcache_i,
    input  logic [2:0]                targ_awprot_i,
    input  logic [3:0]                targ_awregion_i,
    input  logic [AXI_USER_W-1:0]     targ_awuser_i,
    input  logic [3:0]                targ_awqos_i,
    input  logic                      targ_awvalid_i,
    output logic                      targ_awready_o,

    output logic [AXI_ID_W-1:0]       init_awid_o,
    output logic [AXI_ADDRESS_W-1:0]  init_awaddr_o,
    output logic [7:0]                init_awlen_o,
    output logic [2:0]                init_awsize_o,
    output logic [1:0]                init_awburst_o,
    output logic                      init_awlock_o,
    output logic [3:0]                init_awcache_o,
    output logic [2:0]                init_awprot_o,
    output logic [3:0]                init_awregion_o,
    output logic [AXI_USER_W-1:0]     init_awuser_o,
    output logic [3:0]                init_awqos_o,
    output logic                      init_awvalid_o,
    input  logic                      init_awready_i,

    input  logic [AXI_DATA_W-1:0]     targ_wdata_i,
    input  logic [AXI_NUMBYTES-1:0]   targ_wstrb_i,
    input  logic [AXI_USER_W-1:0]     targ_wuser_i,
    input  logic                      targ_wlast_i,
    input  logic                      targ_wvalid_i,
    output logic                      targ_wready_o,

    output logic [AXI_DATA_W-1:0]     init_wdata_o,
    output logic [AXI_NUMBYTES-1:0]   init_wstrb_o,
    output logic [AXI_USER_W-1:0]     init_wuser_o,
    output logic                      init_wlast_o,
    output logic                      init_wvalid_o,
    input  logic                      init_wready_i,

    output logic                      err_wlast_o,
    output logic [$clog2(DEPTH):0]    outstanding_o
);

    logic full;
    logic empty;
    logic aw_hs;
    logic w_hs;
    logic wlast_int;
    len_t head_len;
    len_t beat;
    logic err_wlast_p1;

    axi_len_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AXI_LEN_W)
    ) u_len_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aw_hs),
        .push_data (targ_awlen_i),
        .pop       (w_hs & wlast_int),
        .full      (full),
        .empty     (empty),
        .count     (outstanding_o),
        .head      (head_len)
    );

    assign init_awid_o     = targ_awid_i;
    assign init_awaddr_o   = targ_awaddr_i;
    assign init_awlen_o    = targ_awlen_i;
    assign init_awsize_o   = targ_awsize_i;
    assign init_awburst_o  = targ_awburst_i;
    assign init_awlock_o   = targ_awlock_i;
    assign init_awcache_o  = targ_awcache_i;
    assign init_awprot_o   = targ_awprot_i;
    assign init_awregion_o = targ_awregion_i;
    assign init_awuser_o   = targ_awuser_i;
    assign init_awqos_o    = targ_awqos_i;

    assign init_wdata_o    = targ_wdata_i;
    assign init_wstrb_o    = targ_wstrb_i;
    assign init_wuser_o    = targ_wuser_i;

    assign init_awvalid_o  = targ_awvalid_i & ~full & ~rst;
    assign targ_awready_o  = init_awready_i & ~full & ~rst;
    assign aw_hs           = init_awvalid_o & init_awready_i;

    // W is gated on the registered count, so a burst's beats cannot overtake its AW.
    assign init_wvalid_o   = targ_wvalid_i & ~empty & ~rst;
    assign targ_wready_o   = init_wready_i & ~empty & ~rst;
    assign w_hs            = init_wvalid_o & init_wready_i;

    assign wlast_int       = (beat == head_len) & ~empty;
    assign init_wlast_o    = wlast_int & ~rst;

    // Handshake stage -> beat count and mismatch flag
    always_ff @(posedge clk) begin
        if (rst) begin
            beat         <= '0;
            err_wlast_p1 <= 1'b0;
        end else begin
            err_wlast_p1 <= w_hs & (targ_wlast_i != wlast_int);
            if (w_hs) begin
                beat <= wlast_int ? '0 : beat + 1'b1;
            end
        end
    end

    assign err_wlast_o = err_wlast_p1;

endmodule

// File: tb/tb_axi_w_gate.sv
// Self-checking bench for axi_w_gate: directed scenarios plus a randomized
// back-pressure run checked against a burst-length scoreboard.
`timescale 1ns/1ps
module tb_axi_w_gate;

    localparam int AW_W  = 32;
    localparam int DW    = 64;
    localparam int NB    = DW/8;
    localparam int UW    = 6;
    localparam int IW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH)+1;
    localparam int NBURST = 200;

    typedef struct {
        int len;
        int idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [IW-1:0]   aw_id;
    logic [AW_W-1:0] aw_addr;
    logic [7:0]      aw_len;
    logic [2:0]      aw_size;
    logic [1:0]      aw_burst;
    logic            aw_lock;
    logic [3:0]      aw_cache;
    logic [2:0]      aw_prot;
    logic [3:0]      aw_region;
    logic [UW-1:0]   aw_user;
    logic [3:0]      aw_qos;
    logic            aw_valid;
    logic            aw_ready;
    logic [DW-1:0]   w_data;
    logic [NB-1:0]   w_strb;
    logic [UW-1:0]   w_user;
    logic            w_last;
    logic            w_valid;
    logic            w_ready;

    logic            targ_awready_o;
    logic [IW-1:0]   init_awid_o;
    logic [AW_W-1:0] init_awaddr_o;
    logic [7:0]      init_awlen_o;
    logic [2:0]      init_awsize_o;
    logic [1:0]      init_awburst_o;
    logic            init_awlock_o;
    logic [3:0]      init_awcache_o;
    logic [2:0]      init_awprot_o;
    logic [3:0]      init_awregion_o;
    logic [UW-1:0]   init_awuser_o;
    logic [3:0]      init_awqos_o;
    logic            init_awvalid_o;
    logic            targ_wready_o;
    logic [DW-1:0]   init_wdata_o;
    logic [NB-1:0]   init_wstrb_o;
    logic [UW-1:0]   init_wuser_o;
    logic            init_wlast_o;
    logic            init_wvalid_o;
    logic            err_wlast_o;
    logic [CW-1:0]   outstanding_o;

    int checks;
    int errors;
    int   len_q[$];
    exp_t sb_q[$];

    axi_w_gate #(
        .AXI_ADDRESS_W (AW_W),
        .AXI_DATA_W    (DW),
        .AXI_NUMBYTES  (NB),
        .AXI_USER_W    (UW),
        .AXI_ID_W      (IW),
        .DEPTH         (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .targ_awid_i     (aw_id),
        .targ_awaddr_i   (aw_addr),
        .targ_awlen_i    (aw_len),
        .targ_awsize_i   (aw_size),
        .targ_awburst_i  (aw_burst),
        .targ_awlock_i   (aw_lock),
        .targ_awcache_i  (aw_cache),
        .targ_awprot_i   (aw_prot),
        .targ_awregion_i (aw_region),
        .targ_awuser_i   (aw_user),
        .targ_awqos_i    (aw_qos),
        .targ_awvalid_i  (aw_valid),
        .targ_awready_o  (targ_awready_o),
        .init_awid_o     (init_awid_o),
        .init_awaddr_o   (init_awaddr_o),
        .init_awlen_o    (init_awlen_o),
        .init_awsize_o   (init_awsize_o),
        .init_awburst_o  (init_awburst_o),
        .init_awlock_o   (init_awlock_o),
        .init_awcache_o  (init_awcache_o),
        .init_awprot_o   (init_awprot_o),
        .init_awregion_o (init_awregion_o),
        .init_awuser_o   (init_awuser_o),
        .init_awqos_o    (init_awqos_o),
        .init_awvalid_o  (init_awvalid_o),
        .init_awready_i  (aw_ready),
        .targ_wdata_i    (w_data),
        .targ_wstrb_i    (w_strb),
        .targ_wuser_i    (w_user),
        .targ_wlast_i    (w_last),
        .targ_wvalid_i   (w_valid),
        .targ_wready_o   (targ_wready_o),
        .init_wdata_o    (init_wdata_o),
        .init_wstrb_o    (init_wstrb_o),
        .init_wuser_o    (init_wuser_o),
        .init_wlast_o    (init_wlast_o),
        .init_wvalid_o   (init_wvalid_o),
        .init_wready_i   (w_ready),
        .err_wlast_o     (err_wlast_o),
        .outstanding_o   (outstanding_o)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic aw_send(input int len);
        bit hs;
        hs = 1'b0;
        aw_valid = 1'b1;
        aw_len = 8'(len);
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge clk);
            hs = targ_awready_o && init_awvalid_o;
            @(posedge clk); #1;
        end
        aw_valid = 1'b0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL aw_accept: len=%0d accepted=0, required accepted=1 within 50 cycles", len);
        end else begin
            len_q.push_back(len);
        end
    endtask

    task automatic w_send_burst();
        int len;
        bit hs;
        if (len_q.size() == 0) return;
        len = len_q.pop_front();
        for (int k = 0; k <= len; k++) begin
            w_valid = 1'b1;
            w_last  = (k == len);
            w_data  = 64'(k);
            hs = 1'b0;
            for (int t = 0; t < 50 && !hs; t++) begin
                @(negedge clk);
                hs = init_wvalid_o && targ_wready_o;
                if (hs) begin
                    checks++;
                    if (init_wlast_o !== (k == len)) begin
                        errors++;
                        $display("FAIL wlast_regen: len=%0d beat=%0d got %b, expected %b", len, k, init_wlast_o, (k == len));
                    end
                end
                @(posedge clk); #1;
            end
            if (!hs) begin
                checks++;
                errors++;
                $display("FAIL w_accept: len=%0d beat=%0d not accepted within 50 cycles", len, k);
                w_valid = 1'b0;
                return;
            end
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        aw_valid = 1'b1; w_valid = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({init_awvalid_o, targ_awready_o, init_wvalid_o, targ_wready_o, init_wlast_o, err_wlast_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 000000", {init_awvalid_o, targ_awready_o, init_wvalid_o, targ_wready_o, init_wlast_o, err_wlast_o});
        end
        checks++;
        if (outstanding_o !== CW'(0)) begin
            errors++;
            $display("FAIL reset_outstanding: got %0d, expected 0", outstanding_o);
        end
        @(posedge clk); #1;
        rst = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({targ_awready_o, targ_wready_o, init_wvalid_o} !== 3'b100) begin
            errors++;
            $display("FAIL idle_ready: got %b, expected 100", {targ_awready_o, targ_wready_o, init_wvalid_o});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_burst();
        aw_valid = 1'b1; aw_len = 8'd3; aw_addr = 32'h1000_0040; aw_id = 4'h5;
        w_valid = 1'b1; w_last = 1'b0; w_data = 64'hA0;
        @(negedge clk);
        checks++;
        if ({targ_awready_o, init_awvalid_o, init_wvalid_o} !== 3'b110) begin
            errors++;
            $display("FAIL single_cycle0: aw_rdy/aw_vld/w_vld got %b, expected 110", {targ_awready_o, init_awvalid_o, init_wvalid_o});
        end
        checks++;
        if ({init_awid_o, init_awaddr_o, init_awsize_o, init_awburst_o, init_awlock_o, init_awcache_o,
             init_awprot_o, init_awregion_o, init_awuser_o, init_awqos_o, init_awlen_o} !==
            {4'h5, 32'h1000_0040, 3'd3, 2'b01, 1'b0, 4'h3, 3'h2, 4'h1, 6'h2A, 4'h7, 8'd3}) begin
            errors++;
            $display("FAIL aw_payload: got addr %h id %h, expected addr 10000040 id 5 with fixed sideband", init_awaddr_o, init_awid_o);
        end
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_last = (k == 3);
            w_data = 64'hA0 + 64'(k);
            @(negedge clk);
            checks++;
            if ({init_wvalid_o, init_wlast_o} !== {1'b1, (k == 3)}) begin
                errors++;
                $display("FAIL single_beat%0d: wvalid/wlast got %b%b, expected 1%b", k, init_wvalid_o, init_wlast_o, (k == 3));
            end
            checks++;
            if ({init_wdata_o, init_wstrb_o, init_wuser_o, outstanding_o} !== {64'hA0 + 64'(k), 8'hF0, 6'h15, CW'(1)}) begin
                errors++;
                $display("FAIL single_payload%0d: data %h outstanding %0d, expected data %h outstanding 1", k, init_wdata_o, outstanding_o, 64'hA0 + 64'(k));
            end
            @(posedge clk); #1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({outstanding_o, err_wlast_o} !== {CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL single_done: outstanding %0d err %b, expected 0 0", outstanding_o, err_wlast_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        w_valid = 1'b0;
        for (int i = 0; i < 4; i++) aw_send(i);
        aw_valid = 1'b1; aw_len = 8'd5;
        @(negedge clk);
        checks++;
        if ({outstanding_o, targ_awready_o, init_awvalid_o} !== {CW'(4), 2'b00}) begin
            errors++;
            $display("FAIL full_gate: outstanding %0d awready %b awvalid %b, expected 4 0 0", outstanding_o, targ_awready_o, init_awvalid_o);
        end
        @(posedge clk); #1;
        w_valid = 1'b1; w_last = 1'b1;
        @(negedge clk);
        checks++;
        if ({init_wvalid_o, init_wlast_o, targ_awready_o} !== 3'b110) begin
            errors++;
            $display("FAIL full_len0_beat: wvalid/wlast/awready got %b, expected 110", {init_wvalid_o, init_wlast_o, targ_awready_o});
        end
        @(posedge clk); #1;
        w_valid = 1'b0; w_last = 1'b0;
        void'(len_q.pop_front());
        @(negedge clk);
        checks++;
        if ({outstanding_o, targ_awready_o} !== {CW'(3), 1'b1}) begin
            errors++;
            $display("FAIL full_release: outstanding %0d awready %b, expected 3 1", outstanding_o, targ_awready_o);
        end
        @(posedge clk); #1;
        aw_valid = 1'b0;
        len_q.push_back(5);
        @(negedge clk);
        checks++;
        if (outstanding_o !== CW'(4)) begin
            errors++;
            $display("FAIL full_fifth: outstanding got %0d, expected 4", outstanding_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        // queue holds lens 1,2,3,5 with the FIFO full
        w_valid = 1'b1; w_last = 1'b0;
        @(negedge clk);
        checks++;
        if (init_wlast_o !== 1'b0) begin
            errors++;
            $display("FAIL sim_beat0: wlast got %b, expected 0", init_wlast_o);
        end
        @(posedge clk); #1;
        w_last = 1'b1; aw_valid = 1'b1; aw_len = 8'd6;
        @(negedge clk);
        checks++;
        if ({init_wlast_o, targ_awready_o, outstanding_o} !== {1'b1, 1'b0, CW'(4)}) begin
            errors++;
            $display("FAIL sim_full_pop: wlast %b awready %b outstanding %0d, expected 1 0 4", init_wlast_o, targ_awready_o, outstanding_o);
        end
        @(posedge clk); #1;
        void'(len_q.pop_front());
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({outstanding_o, targ_awready_o} !== {CW'(3), 1'b1}) begin
            errors++;
            $display("FAIL sim_after_pop: outstanding %0d awready %b, expected 3 1", outstanding_o, targ_awready_o);
        end
        @(posedge clk); #1;
        aw_valid = 1'b0;
        len_q.push_back(6);
        @(negedge clk);
        checks++;
        if (outstanding_o !== CW'(4)) begin
            errors++;
            $display("FAIL sim_refill: outstanding got %0d, expected 4", outstanding_o);
        end
        @(posedge clk); #1;
        w_send_burst();
        // head is len 3 with three entries queued; push on its last beat
        w_valid = 1'b1; w_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        w_last = 1'b1; aw_valid = 1'b1; aw_len = 8'd0;
        @(negedge clk);
        checks++;
        if ({init_wlast_o, targ_awready_o, init_awvalid_o, outstanding_o} !== {3'b111, CW'(3)}) begin
            errors++;
            $display("FAIL sim_push_pop: wlast %b awready %b awvalid %b outstanding %0d, expected 1 1 1 3",
                     init_wlast_o, targ_awready_o, init_awvalid_o, outstanding_o);
        end
        @(posedge clk); #1;
        void'(len_q.pop_front());
        len_q.push_back(0);
        w_valid = 1'b0; w_last = 1'b0; aw_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding_o !== CW'(3)) begin
            errors++;
            $display("FAIL sim_cnt_kept: outstanding got %0d, expected 3", outstanding_o);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) w_send_burst();
        @(negedge clk);
        checks++;
        if (outstanding_o !== CW'(0)) begin
            errors++;
            $display("FAIL sim_drained: outstanding got %0d, expected 0", outstanding_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mismatch();
        aw_send(1);
        len_q.delete();
        w_valid = 1'b1; w_last = 1'b1;
        @(negedge clk);
        checks++;
        if ({init_wlast_o, err_wlast_o} !== 2'b00) begin
            errors++;
            $display("FAIL mis_beat0: wlast/err got %b, expected 00", {init_wlast_o, err_wlast_o});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({init_wlast_o, err_wlast_o} !== 2'b11) begin
            errors++;
            $display("FAIL mis_pulse: wlast/err got %b, expected 11", {init_wlast_o, err_wlast_o});
        end
        @(posedge clk); #1;
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({err_wlast_o, outstanding_o} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL mis_end: err %b outstanding %0d, expected 0 0", err_wlast_o, outstanding_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        aw_send(7);
        w_valid = 1'b1; w_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst = 1'b1; aw_valid = 1'b1; aw_len = 8'd2;
        @(negedge clk);
        checks++;
        if ({init_awvalid_o, targ_awready_o, init_wvalid_o, targ_wready_o, init_wlast_o} !== 5'b0) begin
            errors++;
            $display("FAIL rst_gate: got %b, expected 00000", {init_awvalid_o, targ_awready_o, init_wvalid_o, targ_wready_o, init_wlast_o});
        end
        @(posedge clk); #1;
        rst = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        len_q.delete();
        @(negedge clk);
        checks++;
        if ({outstanding_o, err_wlast_o, targ_wready_o} !== {CW'(0), 2'b00}) begin
            errors++;
            $display("FAIL rst_flush: outstanding %0d err %b wready %b, expected 0 0 0", outstanding_o, err_wlast_o, targ_wready_o);
        end
        @(posedge clk); #1;
        aw_send(0);
        w_send_burst();
        @(negedge clk);
        checks++;
        if (outstanding_o !== CW'(0)) begin
            errors++;
            $display("FAIL rst_recover: outstanding got %0d, expected 0", outstanding_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        int lens[NBURST];
        int done;
        bit stop;
        for (int i = 0; i < NBURST; i++) lens[i] = $urandom_range(0, 15);
        done = 0;
        stop = 1'b0;
        sb_q.delete();
        fork
            begin
                for (int b = 0; b < NBURST && !stop; b++) begin
                    bit hs;
                    hs = 1'b0;
                    aw_valid = 1'b1; aw_len = 8'(lens[b]); aw_addr = 32'(b * 64);
                    while (!hs && !stop) begin
                        @(negedge clk);
                        hs = targ_awready_o;
                        @(posedge clk); #1;
                    end
                end
                aw_valid = 1'b0;
            end
            begin
                for (int b = 0; b < NBURST && !stop; b++) begin
                    for (int k = 0; k <= lens[b] && !stop; k++) begin
                        bit hs;
                        hs = 1'b0;
                        w_valid = 1'b1; w_last = (k == lens[b]); w_data = {32'(b), 32'(k)};
                        while (!hs && !stop) begin
                            @(negedge clk);
                            hs = targ_wready_o;
                            @(posedge clk); #1;
                        end
                    end
                end
                w_valid = 1'b0; w_last = 1'b0;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    aw_ready = ($urandom_range(0, 3) != 0);
                    w_ready  = ($urandom_range(0, 2) != 0);
                end
            end
            begin
                int beat_n;
                int aw_idx;
                beat_n = 0;
                aw_idx = 0;
                for (int t = 0; t < 30000 && done < NBURST; t++) begin
                    @(negedge clk);
                    if (init_wvalid_o && w_ready) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL bp_w_before_aw: W beat with data %h forwarded, expected no beat before its AW", init_wdata_o);
                        end else begin
                            checks++;
                            if (init_wdata_o !== {32'(sb_q[0].idx), 32'(beat_n)}) begin
                                errors++;
                                $display("FAIL bp_data: got %h, expected %h", init_wdata_o, {32'(sb_q[0].idx), 32'(beat_n)});
                            end
                            checks++;
                            if (init_wlast_o !== (beat_n == sb_q[0].len)) begin
                                errors++;
                                $display("FAIL bp_wlast: burst %0d beat %0d got %b, expected %b", sb_q[0].idx, beat_n, init_wlast_o, (beat_n == sb_q[0].len));
                            end
                            if (init_wlast_o) begin
                                checks++;
                                if (beat_n + 1 != sb_q[0].len + 1) begin
                                    errors++;
                                    $display("FAIL bp_beat_count: burst %0d got %0d beats, expected %0d", sb_q[0].idx, beat_n + 1, sb_q[0].len + 1);
                                end
                                void'(sb_q.pop_front());
                                done++;
                                beat_n = 0;
                            end else begin
                                beat_n++;
                            end
                        end
                    end
                    if (init_awvalid_o && aw_ready) begin
                        sb_q.push_back('{len: int'(init_awlen_o), idx: aw_idx});
                        aw_idx++;
                    end
                    checks++;
                    if (err_wlast_o !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_err_wlast: got %b, expected 0", err_wlast_o);
                    end
                end
                checks++;
                if (done != NBURST) begin
                    errors++;
                    $display("FAIL bp_complete: got %0d bursts, expected %0d", done, NBURST);
                end
                stop = 1'b1;
            end
        join
        aw_ready = 1'b1; w_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = 3'd3; aw_burst = 2'b01; aw_lock = 1'b0;
        aw_cache = 4'h3; aw_prot = 3'h2; aw_region = 4'h1; aw_user = 6'h2A; aw_qos = 4'h7;
        aw_valid = 1'b0; aw_ready = 1'b1;
        w_data = '0; w_strb = 8'hF0; w_user = 6'h15; w_last = 1'b0; w_valid = 1'b0; w_ready = 1'b1;
        rst = 1'b1;
        test_reset();
        test_single_burst();
        test_full();
        test_simultaneous();
        test_mismatch();
        test_mid_reset();
        test_back_pressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
